// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seven_seg_pkg;

  typedef logic [3:0] nibble_t;

  localparam int DEFAULT_CLK_DIV = 50000;
  localparam int MAX_DIGITS      = 32;

  // One-hot anode pattern for digit idx; inverted when the anodes are active-low.
  function automatic logic [MAX_DIGITS-1:0] anode_onehot(input int unsigned idx,
                                                         input logic        active_low);
    logic [MAX_DIGITS-1:0] oh;
    oh = MAX_DIGITS'(1) << idx;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Free-running divider: tick_o is high for one clk_i cycle out of every CLK_DIV.
module seven_seg_prescaler
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed digit scanner with a double-buffered value that only
// changes on a frame boundary, plus optional leading-zero blanking.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_DIV          = DEFAULT_CLK_DIV,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    blank_lz_i,
  output logic [3:0]              digit_o,
  output logic                    blank_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int            IW      = $clog2(NUM_DIGITS);
  localparam int            VW      = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  logic          tick;
  logic          boundary;
  logic          leading_zero;
  nibble_t       cur_nib;

  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [VW-1:0]         active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  frame_q, frame_d;
  nibble_t               digit_q, digit_d;
  logic                  blank_q, blank_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  seven_seg_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick)
  );

  // Scan index, double buffer and frame strobe.
  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    boundary  = tick && (idx_q == IDX_MAX);
    frame_d   = boundary;

    if (tick) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end

    if (load_i && boundary) begin
      // A load landing on the boundary goes straight to the display.
      shadow_d  = value_i;
      active_d  = value_i;
      pending_d = 1'b0;
    end else if (load_i) begin
      shadow_d  = value_i;
      pending_d = 1'b1;
    end else if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Output stage: looks at the current idx/active, so it trails them by one cycle.
  always_comb begin
    cur_nib      = active_q[4*int'(idx_q) +: 4];
    leading_zero = blank_lz_i && (idx_q != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(idx_q)) && (active_q[4*k +: 4] != 4'h0)) begin
        leading_zero = 1'b0;
      end
    end

    digit_d = cur_nib;
    blank_d = !en_i || leading_zero;
    an_d    = AN_OFF;
    if (!blank_d) begin
      an_d = NUM_DIGITS'(anode_onehot(32'(idx_q), ANODE_ACTIVE_LOW));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      digit_q   <= '0;
      blank_q   <= 1'b1;
      an_q      <= AN_OFF;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      digit_q   <= digit_d;
      blank_q   <= blank_d;
      an_q      <= an_d;
    end
  end

  assign digit_o   = digit_q;
  assign blank_o   = blank_q;
  assign an_o      = an_q;
  assign frame_o   = frame_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, CLK_DIV=4, active-low anodes.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        load_i;
  logic [15:0] value_i;
  logic        blank_lz_i;
  logic [3:0]  digit_o;
  logic        blank_o;
  logic [3:0]  an_o;
  logic        frame_o;
  logic        pending_o;

  int checks = 0;
  int errors = 0;
  logic [3:0] an_tbl [4];

  seven_seg_scan_ctrl #(
    .NUM_DIGITS       (4),
    .CLK_DIV          (4),
    .ANODE_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .load_i     (load_i),
    .value_i    (value_i),
    .blank_lz_i (blank_lz_i),
    .digit_o    (digit_o),
    .blank_o    (blank_o),
    .an_o       (an_o),
    .frame_o    (frame_o),
    .pending_o  (pending_o)
  );

  always #5 clk = ~clk;

  // Bounded wait for the frame strobe; a timeout counts as a failure.
  task automatic wait_frame(input string name);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (frame_o !== 1'b1 && i < 64);
    checks++;
    if (frame_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: frame_o=%b expected 1 within 64 cycles", name, frame_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b0; load_i = 1'b0; value_i = '0; blank_lz_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (an_o !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", an_o); end
    checks++; if (digit_o !== 4'h0) begin errors++; $display("FAIL reset_digit: got %h expected 0", digit_o); end
    checks++; if (blank_o !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b expected 1", blank_o); end
    checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending_o); end
    checks++; if (frame_o !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_scan_basic();
    logic [3:0] exp_dig [4];
    int k;
    exp_dig = '{4'h4, 4'h3, 4'h2, 4'h1};
    en_i = 1'b1; blank_lz_i = 1'b0; load_i = 1'b1; value_i = 16'h1234;
    @(negedge clk);
    load_i = 1'b0;
    checks++; if (pending_o !== 1'b1) begin errors++; $display("FAIL basic_pending_set: got %b expected 1", pending_o); end
    wait_frame("basic_wait_frame");
    checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL basic_pending_clr: got %b expected 0", pending_o); end
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      k = (n - 1) / 4;
      checks++; if (digit_o !== exp_dig[k]) begin errors++; $display("FAIL basic_digit n=%0d: got %h expected %h", n, digit_o, exp_dig[k]); end
      checks++; if (an_o !== an_tbl[k]) begin errors++; $display("FAIL basic_an n=%0d: got %b expected %b", n, an_o, an_tbl[k]); end
      checks++; if (blank_o !== 1'b0) begin errors++; $display("FAIL basic_blank n=%0d: got %b expected 0", n, blank_o); end
      checks++; if (frame_o !== (n == 16)) begin errors++; $display("FAIL basic_frame n=%0d: got %b expected %b", n, frame_o, n == 16); end
    end
  endtask

  task automatic test_no_tearing();
    logic [3:0] old_dig [4];
    logic [3:0] new_dig [4];
    int k;
    old_dig = '{4'h4, 4'h3, 4'h2, 4'h1};
    new_dig = '{4'hD, 4'hC, 4'hB, 4'hA};
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      k = (n - 1) / 4;
      checks++; if (digit_o !== old_dig[k]) begin errors++; $display("FAIL tear_old_digit n=%0d: got %h expected %h", n, digit_o, old_dig[k]); end
      if (n >= 10 && n <= 15) begin
        checks++; if (pending_o !== 1'b1) begin errors++; $display("FAIL tear_pending n=%0d: got %b expected 1", n, pending_o); end
      end
      if (n == 9) begin load_i = 1'b1; value_i = 16'hABCD; end
      if (n == 10) load_i = 1'b0;
    end
    checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL tear_pending_clr: got %b expected 0", pending_o); end
    checks++; if (frame_o !== 1'b1) begin errors++; $display("FAIL tear_frame: got %b expected 1", frame_o); end
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      k = (n - 1) / 4;
      checks++; if (digit_o !== new_dig[k]) begin errors++; $display("FAIL tear_new_digit n=%0d: got %h expected %h", n, digit_o, new_dig[k]); end
      checks++; if (an_o !== an_tbl[k]) begin errors++; $display("FAIL tear_an n=%0d: got %b expected %b", n, an_o, an_tbl[k]); end
      checks++; if (frame_o !== (n == 16)) begin errors++; $display("FAIL tear_frame n=%0d: got %b expected %b", n, frame_o, n == 16); end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] exp_dig [4];
    logic       exp_blk [4];
    logic [3:0] exp_an;
    int k;
    blank_lz_i = 1'b1; load_i = 1'b1; value_i = 16'h0005;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      load_i = 1'b0;
    end
    exp_dig = '{4'h5, 4'h0, 4'h0, 4'h0};
    exp_blk = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      k = (n - 1) / 4;
      exp_an = exp_blk[k] ? 4'b1111 : an_tbl[k];
      checks++; if (digit_o !== exp_dig[k]) begin errors++; $display("FAIL lz5_digit n=%0d: got %h expected %h", n, digit_o, exp_dig[k]); end
      checks++; if (blank_o !== exp_blk[k]) begin errors++; $display("FAIL lz5_blank n=%0d: got %b expected %b", n, blank_o, exp_blk[k]); end
      checks++; if (an_o !== exp_an) begin errors++; $display("FAIL lz5_an n=%0d: got %b expected %b", n, an_o, exp_an); end
      if (n == 1) begin load_i = 1'b1; value_i = 16'h0000; end
      if (n == 2) load_i = 1'b0;
    end
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      k = (n - 1) / 4;
      exp_an = (k == 0) ? 4'b1110 : 4'b1111;
      checks++; if (digit_o !== 4'h0) begin errors++; $display("FAIL lz0_digit n=%0d: got %h expected 0", n, digit_o); end
      checks++; if (blank_o !== (k != 0)) begin errors++; $display("FAIL lz0_blank n=%0d: got %b expected %b", n, blank_o, k != 0); end
      checks++; if (an_o !== exp_an) begin errors++; $display("FAIL lz0_an n=%0d: got %b expected %b", n, an_o, exp_an); end
    end
  endtask

  task automatic test_boundary_load();
    logic [3:0] exp_dig [4];
    logic       exp_blk [4];
    logic [3:0] exp_an;
    int k;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL bnd_pending n=%0d: got %b expected 0", n, pending_o); end
      if (n == 15) begin load_i = 1'b1; value_i = 16'h00F0; end
      if (n == 16) load_i = 1'b0;
    end
    checks++; if (frame_o !== 1'b1) begin errors++; $display("FAIL bnd_frame: got %b expected 1", frame_o); end
    exp_dig = '{4'h0, 4'hF, 4'h0, 4'h0};
    exp_blk = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      k = (n - 1) / 4;
      exp_an = exp_blk[k] ? 4'b1111 : an_tbl[k];
      checks++; if (digit_o !== exp_dig[k]) begin errors++; $display("FAIL bnd_digit n=%0d: got %h expected %h", n, digit_o, exp_dig[k]); end
      checks++; if (an_o !== exp_an) begin errors++; $display("FAIL bnd_an n=%0d: got %b expected %b", n, an_o, exp_an); end
      if (n == 2) begin load_i = 1'b1; value_i = 16'h1357; end
      if (n == 3) load_i = 1'b0;
      if (n == 6) begin load_i = 1'b1; value_i = 16'h2468; end
      if (n == 7) load_i = 1'b0;
    end
  endtask

  task automatic test_enable_and_reset();
    logic [3:0] exp_dig [4];
    logic [3:0] exp_an;
    logic       exp_blank;
    int k;
    exp_dig = '{4'h8, 4'h6, 4'h4, 4'h2};
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      k = (n - 1) / 4;
      exp_blank = (n >= 6 && n <= 12);
      exp_an    = exp_blank ? 4'b1111 : an_tbl[k];
      checks++; if (digit_o !== exp_dig[k]) begin errors++; $display("FAIL en_digit n=%0d: got %h expected %h", n, digit_o, exp_dig[k]); end
      checks++; if (blank_o !== exp_blank) begin errors++; $display("FAIL en_blank n=%0d: got %b expected %b", n, blank_o, exp_blank); end
      checks++; if (an_o !== exp_an) begin errors++; $display("FAIL en_an n=%0d: got %b expected %b", n, an_o, exp_an); end
      if (n == 5) en_i = 1'b0;
      if (n == 12) en_i = 1'b1;
    end
    checks++; if (frame_o !== 1'b1) begin errors++; $display("FAIL en_frame: got %b expected 1", frame_o); end
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 3) begin load_i = 1'b1; value_i = 16'h9999; end
      if (n == 4) begin
        checks++; if (pending_o !== 1'b1) begin errors++; $display("FAIL rst_pending_set: got %b expected 1", pending_o); end
        load_i = 1'b0;
      end
      if (n == 6) rst_ni = 1'b0;
    end
    checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL rst_pending_clr: got %b expected 0", pending_o); end
    checks++; if (an_o !== 4'b1111) begin errors++; $display("FAIL rst_an: got %b expected 1111", an_o); end
    checks++; if (blank_o !== 1'b1) begin errors++; $display("FAIL rst_blank: got %b expected 1", blank_o); end
    rst_ni = 1'b1;
    for (int m = 1; m <= 16; m++) begin
      @(negedge clk);
      k = (m - 1) / 4;
      exp_an = (k == 0) ? 4'b1110 : 4'b1111;
      checks++; if (digit_o !== 4'h0) begin errors++; $display("FAIL rst_digit m=%0d: got %h expected 0", m, digit_o); end
      checks++; if (an_o !== exp_an) begin errors++; $display("FAIL rst_an m=%0d: got %b expected %b", m, an_o, exp_an); end
      checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL rst_pending m=%0d: got %b expected 0", m, pending_o); end
      checks++; if (frame_o !== (m == 16)) begin errors++; $display("FAIL rst_frame m=%0d: got %b expected %b", m, frame_o, m == 16); end
    end
  endtask

  initial begin
    an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    test_reset();
    test_scan_basic();
    test_no_tearing();
    test_leading_zero();
    test_boundary_load();
    test_enable_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
